interface_s_to_sigma: RTL and testbench



---
 rtl/interface_s_to_sigma_if.sv | 34 +++
 rtl/interface_s_to_sigma.sv | 194 +++++++++++++++++++
 tb/tb_interface_s_to_sigma.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/interface_s_to_sigma_if.sv
// interface_s_to_sigma_if: port bundle of the S-to-Sigma stage.
// ext_* select/strobe/syndromes in; ready, s0..s3, vec_idx out.
interface interface_s_to_sigma_if;
  logic       ext_en;
  logic       ext_signal;
  logic [7:0] ext_w1;
  logic [7:0] ext_w2;
  logic [7:0] ext_w3;
  logic [7:0] ext_w4;
  logic [7:0] ext_w5;
  logic [7:0] ext_w6;
  logic       ready;
  logic [7:0] s0;
  logic [7:0] s1;
  logic [7:0] s2;
  logic [7:0] s3;
  logic [2:0] vec_idx;

  modport master (
    output ext_en, ext_signal,
    output ext_w1, ext_w2, ext_w3,
    output ext_w4, ext_w5, ext_w6,
    input  ready, s0, s1, s2, s3,
    input  vec_idx
  );

  modport slave (
    input  ext_en, ext_signal,
    input  ext_w1, ext_w2, ext_w3,
    input  ext_w4, ext_w5, ext_w6,
    output ready, s0, s1, s2, s3,
    output vec_idx
  );
endinterface

// File: rtl/interface_s_to_sigma.sv
// interface_s_to_sigma: Berlekamp-Massey S-to-Sigma core (t=3, GF(2^8)/0x11D)
// plus a 16-cycle syndrome ROM sequencer. Ports: clk, rst, bus (slave).
module interface_s_to_sigma (
  input  logic clk,
  input  logic rst,
  interface_s_to_sigma_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, DISC, UPDT, DONE
  } state_t;

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ ({8{x[7]}} & 8'h1d);
    end
    return p;
  endfunction

  // a^254 = a^-1: product of the squares a^2 .. a^128
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [3:0] cnt;
  logic [2:0] vidx;
  logic [7:0] rom [1:6];
  logic [7:0] win [1:6];
  logic       start;

  state_t     state, nxt;
  logic [7:0] syn [1:6];
  logic [7:0] sx  [0:6];
  logic [7:0] sig [0:3];
  logic [7:0] bb  [0:3];
  logic [7:0] xb  [0:3];
  logic [7:0] signew [0:3];
  logic [7:0] so  [0:3];
  logic [2:0] len, mm, rr;
  logic [7:0] binv, delta, disc, q;
  logic       grow, rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      vidx <= '0;
    end else begin
      cnt <= cnt + 4'd1;
      if (cnt == 4'd0)
        vidx <= (vidx == 3'd5) ? 3'd0 : vidx + 3'd1;
    end
  end

  always_comb begin
    case (vidx)
      3'd0, 3'd5:
        rom = '{8'd215, 8'd2, 8'd148, 8'd39, 8'd1, 8'd54};
      3'd1:
        rom = '{8'd48, 8'd105, 8'd235, 8'd248, 8'd183, 8'd239};
      3'd2:
        rom = '{8'd5, 8'd3, 8'd15, 8'd23, 8'd39, 8'd71};
      3'd3:
        rom = '{8'd124, 8'd14, 8'd3, 8'd23, 8'd39, 8'd15};
      3'd4:
        rom = '{8'd200, 8'd14, 8'd1, 8'd15, 8'd132, 8'd15};
      default:
        rom = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    endcase
  end

  always_comb begin
    if (bus.ext_en) begin
      start = bus.ext_signal;
      win = '{bus.ext_w1, bus.ext_w2, bus.ext_w3,
              bus.ext_w4, bus.ext_w5, bus.ext_w6};
    end else begin
      start = (cnt == 4'd0);
      win = rom;
    end
  end

  // sx[0] = 0 lets the discrepancy sum run i = 0..3 without range guards
  always_comb begin
    sx[0] = '0;
    for (int k = 1; k < 7; k++) sx[k] = syn[k];
    disc = '0;
    for (int i = 0; i < 4; i++)
      if (3'(i) <= rr)
        disc = disc ^ gf_mul(sig[i], sx[rr - 3'(i)]);
  end

  always_comb begin
    q = gf_mul(delta, binv);
    for (int j = 0; j < 4; j++) begin
      xb[j] = '0;
      if (3'(j) >= mm) xb[j] = bb[2'(3'(j) - mm)];
      signew[j] = sig[j] ^ gf_mul(q, xb[j]);
    end
  end

  // 2L <= r-1
  assign grow = ({len, 1'b0} < {1'b0, rr});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = LOAD;
      LOAD: nxt = DISC;
      DISC: nxt = UPDT;
      UPDT: nxt = (rr == 3'd6) ? DONE : DISC;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      syn   <= '{default: 8'h00};
      sig   <= '{8'h01, 8'h00, 8'h00, 8'h00};
      bb    <= '{8'h01, 8'h00, 8'h00, 8'h00};
      so    <= '{8'h01, 8'h00, 8'h00, 8'h00};
      len   <= '0;
      mm    <= 3'd1;
      rr    <= 3'd1;
      binv  <= 8'h01;
      delta <= '0;
      rdy   <= 1'b0;
    end else begin
      rdy <= 1'b0;
      unique case (state)
        IDLE: if (start) syn <= win;
        LOAD: begin
          sig  <= '{8'h01, 8'h00, 8'h00, 8'h00};
          bb   <= '{8'h01, 8'h00, 8'h00, 8'h00};
          len  <= '0;
          mm   <= 3'd1;
          rr   <= 3'd1;
          binv <= 8'h01;
        end
        DISC: delta <= disc;
        UPDT: begin
          rr <= rr + 3'd1;
          if (delta == 8'h00) begin
            mm <= mm + 3'd1;
          end else begin
            sig <= signew;
            if (grow) begin
              len  <= rr - len;
              bb   <= sig;
              binv <= gf_inv(delta);
              mm   <= 3'd1;
            end else begin
              mm <= mm + 3'd1;
            end
          end
        end
        DONE: begin
          so  <= sig;
          rdy <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready   = rdy;
  assign bus.s0      = so[0];
  assign bus.s1      = so[1];
  assign bus.s2      = so[2];
  assign bus.s3      = so[3];
  assign bus.vec_idx = vidx;

endmodule

// File: tb/tb_interface_s_to_sigma.sv
// tb_interface_s_to_sigma: scoreboard bench for interface_s_to_sigma.
// Directed ext_* cases plus a sequencer run against a BM reference model.
module tb_interface_s_to_sigma;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  interface_s_to_sigma_if bus_i ();

  interface_s_to_sigma dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  typedef struct {
    logic [31:0] sig;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [7:0] gexp [0:254];
  int         glog [0:255];
  logic [7:0] rom  [6][6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @cyc %0d",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] fmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    if (a == 0 || b == 0) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  function automatic logic [7:0] finv(input logic [7:0] a);
    return gexp[(255 - glog[a]) % 255];
  endfunction

  function automatic logic [31:0] bm_model(
    input logic [7:0] w [6]
  );
    logic [7:0] s [4];
    logic [7:0] b [4];
    logic [7:0] t [4];
    logic [7:0] d, bc, f;
    int l, m;
    s = '{8'h01, 8'h00, 8'h00, 8'h00};
    b = '{8'h01, 8'h00, 8'h00, 8'h00};
    l = 0;
    m = 1;
    bc = 8'h01;
    for (int r = 1; r <= 6; r++) begin
      d = 8'h00;
      for (int i = 0; i < 4; i++)
        if (r - i >= 1) d = d ^ fmul(s[i], w[r - i - 1]);
      if (d == 8'h00) begin
        m++;
      end else begin
        t = s;
        f = fmul(d, finv(bc));
        for (int j = 0; j < 4; j++)
          if (j >= m) s[j] = s[j] ^ fmul(f, b[j - m]);
        if (2 * l <= r - 1) begin
          l = r - l;
          b = t;
          bc = d;
          m = 1;
        end else begin
          m++;
        end
      end
    end
    return {s[0], s[1], s[2], s[3]};
  endfunction

  function automatic logic [31:0] rom_exp(input int k);
    logic [7:0] v [6];
    for (int i = 0; i < 6; i++) v[i] = rom[k][i];
    return bm_model(v);
  endfunction

  function automatic logic [31:0] sigma_out();
    return {bus_i.s0, bus_i.s1, bus_i.s2, bus_i.s3};
  endfunction

  initial begin
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x[7:0];
      glog[x] = i;
      x = x << 1;
      if (x & 256) x = x ^ 'h11d;
    end
    glog[0] = 0;
    rom[0] = '{8'd215, 8'd2, 8'd148, 8'd39, 8'd1, 8'd54};
    rom[1] = '{8'd48, 8'd105, 8'd235, 8'd248, 8'd183, 8'd239};
    rom[2] = '{8'd5, 8'd3, 8'd15, 8'd23, 8'd39, 8'd71};
    rom[3] = '{8'd124, 8'd14, 8'd3, 8'd23, 8'd39, 8'd15};
    rom[4] = '{8'd200, 8'd14, 8'd1, 8'd15, 8'd132, 8'd15};
    rom[5] = '{8'd215, 8'd2, 8'd148, 8'd39, 8'd1, 8'd54};
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_i.ready === 1'b1) begin
      check("ready_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("sigma", sigma_out(), e.sig);
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic set_w(
    input logic [7:0] a, b, c, d, e, f
  );
    bus_i.ext_w1 = a;
    bus_i.ext_w2 = b;
    bus_i.ext_w3 = c;
    bus_i.ext_w4 = d;
    bus_i.ext_w5 = e;
    bus_i.ext_w6 = f;
  endtask

  task automatic ext_start(
    input logic [7:0]  a, b, c, d, e, f,
    input logic [31:0] sig
  );
    set_w(a, b, c, d, e, f);
    bus_i.ext_signal = 1'b1;
    q.push_back('{sig: sig, cyc: cyc + 1 + 14});
    @(negedge clk);
    bus_i.ext_signal = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(bus_i.ready), 32'd0);
    check({tag, "_sigma"}, sigma_out(), 32'h0100_0000);
    check({tag, "_vec"}, 32'(bus_i.vec_idx), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, rr;
    rst = 1'b1;
    bus_i.ext_en = 1'b1;
    bus_i.ext_signal = 1'b0;
    set_w(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    ext_start(0, 0, 0, 0, 0, 0, 32'h0100_0000);
    drain(40);
    ext_start(2, 4, 8, 16, 32, 64, 32'h0102_0000);
    drain(40);
    ext_start(6, 20, 72, 13, 84, 141, 32'h0106_0800);
    drain(40);

    // second strobe lands while busy and must be dropped
    ext_start(7, 21, 73, 12, 85, 140, 32'h0107_0e08);
    repeat (3) @(negedge clk);
    set_w(0, 0, 0, 0, 0, 0);
    bus_i.ext_signal = 1'b1;
    @(negedge clk);
    bus_i.ext_signal = 1'b0;
    drain(40);
    repeat (20) @(negedge clk);
    check("hold", sigma_out(), 32'h0107_0e08);

    rst = 1'b1;
    bus_i.ext_en = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset2");
    rst = 1'b0;
    t0 = cyc + 1;
    for (int k = 0; k < 7; k++) begin
      while (cyc != t0 + 16 * k - 1) @(negedge clk);
      check("vec_idx", 32'(bus_i.vec_idx), 32'(k % 6));
      q.push_back('{sig: rom_exp(k % 6), cyc: t0 + 16 * k + 14});
      @(negedge clk);
    end

    // abort the in-flight computation for the wrapped entry 0
    while (cyc != t0 + 96 + 6) @(negedge clk);
    rst = 1'b1;
    if (q.size() != 0) void'(q.pop_back());
    repeat (3) @(negedge clk);
    check_reset("reset3");
    check("aborted_pending", 32'(q.size()), 32'd0);
    rst = 1'b0;
    rr = cyc + 1;
    q.push_back('{sig: rom_exp(0), cyc: rr + 14});
    drain(40);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
